// File: rtl/parity_vector_gen_pkg.sv
// Shared encodings for the parity vector generator: vector sources and FSM states.
package parity_vector_pkg;

    typedef enum logic [1:0] {
        SRC_TABLE = 2'd0,
        SRC_LFSR  = 2'd1,
        SRC_WALK  = 2'd2,
        SRC_RSVD  = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/parity_vector_gen_if.sv
// Vector stream from the generator to a parity checker: data, expected parity, index, valid/ready.
interface parity_vector_gen_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic [WIDTH-1:0] data_out;
    logic             exp_parity;
    logic             data_valid;
    logic             data_ready;
    logic [AW-1:0]    vec_idx;

    modport master (output data_out, exp_parity, data_valid, vec_idx, input data_ready);
    modport slave  (input data_out, exp_parity, data_valid, vec_idx, output data_ready);
endinterface

// File: rtl/parity_lfsr.sv
// Galois LFSR (right-shifting) with synchronous reload; nxt exposes the stepped value combinationally.
module parity_lfsr #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);
    // An all-zero seed would lock the register, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_FIX = (SEED == '0) ? WIDTH'(1) : SEED;

    assign nxt = {1'b0, q[WIDTH-1:1]} ^ (q[0] ? TAPS : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q <= SEED_FIX;
        else if (load) q <= SEED_FIX;
        else if (step) q <= nxt;
    end
endmodule

// File: rtl/parity_vector_gen.sv
// Clocked parity stimulus source: table / LFSR / walking-one vectors with expected even parity
// over a valid/ready stream, one-shot or looping, with a programmable hold between vectors.
module parity_vector_gen
    import parity_vector_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter int               HOLD_CYCLES = 20,
    parameter logic [WIDTH-1:0] LFSR_TAPS   = 8'hB8,
    parameter logic [WIDTH-1:0] LFSR_SEED   = 8'h01,
    localparam int              AW          = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop_req,
    input  logic                 loop_en,
    input  logic [1:0]           src_sel,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    parity_vector_gen_if.master  vo,
    output logic                 busy,
    output logic                 done
);
    localparam logic [WIDTH-1:0] SEED_FIX  = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;
    localparam int               HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_e                      state;
    src_e                        src_q;
    logic                        loop_q;
    logic [AW-1:0]               idx;
    logic [HW-1:0]               hold_cnt;
    logic [DEPTH-1:0][WIDTH-1:0] tbl;
    logic [WIDTH-1:0]            dout;
    logic                        par, vld, busy_q, done_q;
    logic [WIDTH-1:0]            lfsr_q, lfsr_nxt;
    logic                        start_go, accept, last;
    logic [AW-1:0]               nidx;
    logic [WIDTH-1:0]            nv_start, nv_b2b, nv_hold;

    function automatic logic [WIDTH-1:0] vec_of(src_e s, logic [AW-1:0] i, logic [WIDTH-1:0] l);
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] one;
        one = WIDTH'(1);
        case (s)
            SRC_LFSR: v = l;
            SRC_WALK: v = one << (int'(i) % WIDTH);
            default:  v = tbl[i];
        endcase
        return v;
    endfunction

    assign start_go = (state == ST_IDLE || state == ST_DONE) && start && !stop_req;
    assign accept   = (state == ST_EMIT) && vo.data_ready && !stop_req;
    assign last     = (idx == AW'(DEPTH - 1));
    assign nidx     = last ? '0 : idx + 1'b1;

    // Back-to-back advance sees the LFSR value it is about to step to; after a hold it has already stepped.
    assign nv_start = vec_of(src_e'(src_sel), '0, SEED_FIX);
    assign nv_b2b   = vec_of(src_q, nidx, lfsr_nxt);
    assign nv_hold  = vec_of(src_q, nidx, lfsr_q);

    parity_lfsr #(.WIDTH(WIDTH), .TAPS(LFSR_TAPS), .SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_go),
        .step  (accept),
        .q     (lfsr_q),
        .nxt   (lfsr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            src_q    <= SRC_TABLE;
            loop_q   <= 1'b0;
            idx      <= '0;
            hold_cnt <= '0;
            tbl      <= '0;
            dout     <= '0;
            par      <= 1'b0;
            vld      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // The table is frozen for the duration of a run.
            if (wr_en && !busy_q && int'(wr_addr) < DEPTH) tbl[wr_addr] <= wr_data;

            if (stop_req) begin
                state  <= ST_IDLE;
                vld    <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state  <= ST_EMIT;
                            src_q  <= src_e'(src_sel);
                            loop_q <= loop_en;
                            idx    <= '0;
                            dout   <= nv_start;
                            par    <= ^nv_start;
                            vld    <= 1'b1;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                        end
                    end
                    ST_EMIT: begin
                        if (vo.data_ready) begin
                            if (last && !loop_q) begin
                                state  <= ST_DONE;
                                vld    <= 1'b0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else if (HOLD_CYCLES > 0) begin
                                state    <= ST_HOLD;
                                vld      <= 1'b0;
                                hold_cnt <= '0;
                            end else begin
                                idx  <= nidx;
                                dout <= nv_b2b;
                                par  <= ^nv_b2b;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state <= ST_EMIT;
                            idx   <= nidx;
                            dout  <= nv_hold;
                            par   <= ^nv_hold;
                            vld   <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign vo.data_out   = dout;
    assign vo.exp_parity = par;
    assign vo.data_valid = vld;
    assign vo.vec_idx    = idx;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_parity_vector_gen.sv
// Scoreboard bench: dut_a holds 20 cycles between vectors, dut_b runs back-to-back; both share control inputs.
module tb_parity_vector_gen;
    import parity_vector_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 2;
    localparam int GAP_A = 21;
    localparam int GAP_B = 1;

    typedef struct packed {
        logic [W-1:0]  d;
        logic          p;
        logic [AW-1:0] i;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop_req = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
    logic [1:0]    src_sel = 2'd0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          busy_a, done_a, busy_b, done_b;

    logic [W-1:0]  tv [4] = '{8'hFD, 8'h0C, 8'h64, 8'hFF};
    bit            rp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    exp_t qa[$];
    exp_t qb[$];
    int   pass_cnt = 0, chk_cnt = 0, cyc = 0;
    int   last_a = -1, last_b = -1;
    bit   mon_a = 0, mon_b = 0, gap_a = 0, gap_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parity_vector_gen_if #(.WIDTH(W), .AW(AW)) va ();
    parity_vector_gen_if #(.WIDTH(W), .AW(AW)) vb ();

    parity_vector_gen #(.WIDTH(W), .DEPTH(D), .HOLD_CYCLES(20), .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req), .loop_en(loop_en),
        .src_sel(src_sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .vo(va), .busy(busy_a), .done(done_a));

    parity_vector_gen #(.WIDTH(W), .DEPTH(D), .HOLD_CYCLES(0), .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req), .loop_en(loop_en),
        .src_sel(src_sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .vo(vb), .busy(busy_b), .done(done_b));

    function automatic exp_t mk(logic [W-1:0] d, int i);
        exp_t e;
        e.d = d;
        e.p = ^d;
        e.i = AW'(i);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_a && va.data_valid && va.data_ready) begin
            chk_cnt++;
            if (qa.size() == 0) begin
                $display("FAIL sb_a unexpected vector: got data=%h par=%b idx=%0d, expected none",
                         va.data_out, va.exp_parity, va.vec_idx);
            end else begin
                e = qa.pop_front();
                if ({va.data_out, va.exp_parity, va.vec_idx} !== e)
                    $display("FAIL sb_a vector: got data=%h par=%b idx=%0d, expected data=%h par=%b idx=%0d",
                             va.data_out, va.exp_parity, va.vec_idx, e.d, e.p, e.i);
                else pass_cnt++;
            end
            if (gap_a && last_a >= 0) begin
                chk_cnt++;
                if (cyc - last_a !== GAP_A) $display("FAIL gap_a: got %0d cycles, expected %0d", cyc - last_a, GAP_A);
                else pass_cnt++;
            end
            last_a = cyc;
        end
        if (mon_b && vb.data_valid && vb.data_ready) begin
            chk_cnt++;
            if (qb.size() == 0) begin
                $display("FAIL sb_b unexpected vector: got data=%h par=%b idx=%0d, expected none",
                         vb.data_out, vb.exp_parity, vb.vec_idx);
            end else begin
                e = qb.pop_front();
                if ({vb.data_out, vb.exp_parity, vb.vec_idx} !== e)
                    $display("FAIL sb_b vector: got data=%h par=%b idx=%0d, expected data=%h par=%b idx=%0d",
                             vb.data_out, vb.exp_parity, vb.vec_idx, e.d, e.p, e.i);
                else pass_cnt++;
            end
            if (gap_b && last_b >= 0) begin
                chk_cnt++;
                if (cyc - last_b !== GAP_B) $display("FAIL gap_b: got %0d cycles, expected %0d", cyc - last_b, GAP_B);
                else pass_cnt++;
            end
            last_b = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] s, input logic l);
        src_sel = s;
        loop_en = l;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic do_stop();
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
    endtask

    task automatic test_reset();
        va.data_ready = 1'b0;
        vb.data_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if ({va.data_out, va.exp_parity, va.data_valid, va.vec_idx, busy_a, done_a} !== '0)
            $display("FAIL reset_a: got data=%h par=%b vld=%b idx=%0d busy=%b done=%b, expected all 0",
                     va.data_out, va.exp_parity, va.data_valid, va.vec_idx, busy_a, done_a);
        else pass_cnt++;
        chk_cnt++;
        if ({vb.data_out, vb.exp_parity, vb.data_valid, vb.vec_idx, busy_b, done_b} !== '0)
            $display("FAIL reset_b: got data=%h par=%b vld=%b idx=%0d busy=%b done=%b, expected all 0",
                     vb.data_out, vb.exp_parity, vb.data_valid, vb.vec_idx, busy_b, done_b);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_table_oneshot();
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; wr_addr = AW'(k); wr_data = tv[k];
            tick();
        end
        wr_en = 1'b0;
        qa.delete();
        for (int k = 0; k < 4; k++) qa.push_back(mk(tv[k], k));
        mon_a = 1; gap_a = 1; last_a = -1;
        va.data_ready = 1'b1;
        pulse_start(2'(SRC_TABLE), 1'b0);
        chk_cnt++;
        if (va.data_valid !== 1'b1 || va.data_out !== tv[0] || busy_a !== 1'b1)
            $display("FAIL first_latency: got vld=%b data=%h busy=%b, expected vld=1 data=%h busy=1",
                     va.data_valid, va.data_out, busy_a, tv[0]);
        else pass_cnt++;
        for (int i = 0; i < 200 && done_a !== 1'b1; i++) tick();
        chk_cnt++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || va.data_valid !== 1'b0)
            $display("FAIL oneshot_done: got done=%b busy=%b vld=%b, expected done=1 busy=0 vld=0",
                     done_a, busy_a, va.data_valid);
        else pass_cnt++;
        chk_cnt++;
        if (qa.size() !== 0) $display("FAIL oneshot_count: got %0d vectors outstanding, expected 0", qa.size());
        else pass_cnt++;
        mon_a = 0; gap_a = 0;
        va.data_ready = 1'b0;
        do_stop();
    endtask

    task automatic test_back_to_back();
        qb.delete();
        for (int k = 0; k < 6; k++) qb.push_back(mk(tv[k % 4], k % 4));
        mon_b = 1; gap_b = 1; last_b = -1;
        vb.data_ready = 1'b1;
        pulse_start(2'(SRC_TABLE), 1'b1);
        for (int i = 0; i < 40 && qb.size() != 0; i++) tick();
        vb.data_ready = 1'b0;
        chk_cnt++;
        if (qb.size() !== 0) $display("FAIL loop_count: got %0d vectors outstanding, expected 0", qb.size());
        else pass_cnt++;
        chk_cnt++;
        if (done_b !== 1'b0 || busy_b !== 1'b1)
            $display("FAIL loop_state: got done=%b busy=%b, expected done=0 busy=1", done_b, busy_b);
        else pass_cnt++;
        mon_b = 0; gap_b = 0;
        do_stop();
    endtask

    task automatic test_ready_toggle();
        logic [W-1:0] prev_d;
        logic         prev_v;
        bit           r;
        qb.delete();
        for (int k = 0; k < 4; k++) qb.push_back(mk(tv[k], k));
        mon_b = 1;
        pulse_start(2'(SRC_TABLE), 1'b0);
        for (int i = 0; i < 60 && done_b !== 1'b1; i++) begin
            prev_d = vb.data_out;
            prev_v = vb.data_valid;
            r = rp[i % 4];
            vb.data_ready = r;
            tick();
            if (prev_v && !r) begin
                chk_cnt++;
                if (vb.data_out !== prev_d || vb.data_valid !== 1'b1)
                    $display("FAIL ready_freeze: got data=%h vld=%b, expected data=%h vld=1",
                             vb.data_out, vb.data_valid, prev_d);
                else pass_cnt++;
            end
        end
        vb.data_ready = 1'b0;
        chk_cnt++;
        if (qb.size() !== 0 || done_b !== 1'b1)
            $display("FAIL ready_complete: got %0d outstanding done=%b, expected 0 outstanding done=1",
                     qb.size(), done_b);
        else pass_cnt++;
        mon_b = 0;
        do_stop();
    endtask

    task automatic test_sources();
        logic [W-1:0] l;
        va.data_ready = 1'b1;
        mon_a = 1; gap_a = 1;
        for (int s = 0; s < 2; s++) begin
            qa.delete();
            last_a = -1;
            l = 8'h01;
            for (int k = 0; k < 4; k++) begin
                if (s == 0) begin
                    qa.push_back(mk(8'h01 << k, k));
                end else begin
                    qa.push_back(mk(l, k));
                    l = {1'b0, l[W-1:1]} ^ (l[0] ? 8'hB8 : 8'h00);
                end
            end
            pulse_start(s == 0 ? 2'(SRC_WALK) : 2'(SRC_LFSR), 1'b0);
            for (int i = 0; i < 200 && done_a !== 1'b1; i++) tick();
            chk_cnt++;
            if (qa.size() !== 0 || done_a !== 1'b1)
                $display("FAIL src_%0d_run: got %0d outstanding done=%b, expected 0 outstanding done=1",
                         s, qa.size(), done_a);
            else pass_cnt++;
        end
        mon_a = 0; gap_a = 0;
        va.data_ready = 1'b0;
        do_stop();
    endtask

    task automatic test_stop_restart();
        qa.delete();
        qa.push_back(mk(tv[0], 0));
        mon_a = 1; gap_a = 0;
        va.data_ready = 1'b1;
        pulse_start(2'(SRC_TABLE), 1'b0);
        for (int i = 0; i < 10 && qa.size() != 0; i++) tick();
        va.data_ready = 1'b0;
        // Both of these land while dut_a is busy and must have no effect on it.
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'h00; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        for (int i = 0; i < 40 && va.data_valid !== 1'b1; i++) tick();
        tick();
        chk_cnt++;
        if (va.data_valid !== 1'b1 || va.data_out !== tv[1] || va.vec_idx !== 2'd1)
            $display("FAIL second_vec: got vld=%b data=%h idx=%0d, expected vld=1 data=%h idx=1",
                     va.data_valid, va.data_out, va.vec_idx, tv[1]);
        else pass_cnt++;
        do_stop();
        chk_cnt++;
        if (va.data_valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0)
            $display("FAIL stop: got vld=%b busy=%b done=%b, expected vld=0 busy=0 done=0",
                     va.data_valid, busy_a, done_a);
        else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if (va.data_valid !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL stop_idle: got vld=%b busy=%b, expected vld=0 busy=0", va.data_valid, busy_a);
        else pass_cnt++;
        qa.delete();
        for (int k = 0; k < 4; k++) qa.push_back(mk(tv[k], k));
        gap_a = 1; last_a = -1;
        va.data_ready = 1'b1;
        pulse_start(2'(SRC_TABLE), 1'b0);
        for (int i = 0; i < 200 && done_a !== 1'b1; i++) tick();
        chk_cnt++;
        if (qa.size() !== 0 || done_a !== 1'b1)
            $display("FAIL restart: got %0d outstanding done=%b, expected 0 outstanding done=1", qa.size(), done_a);
        else pass_cnt++;
        mon_a = 0; gap_a = 0;
        va.data_ready = 1'b0;
        do_stop();
    endtask

    task automatic test_async_reset();
        qa.delete();
        qa.push_back(mk(tv[0], 0));
        mon_a = 1; gap_a = 0;
        va.data_ready = 1'b1;
        pulse_start(2'(SRC_TABLE), 1'b0);
        for (int i = 0; i < 10 && qa.size() != 0; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        chk_cnt++;
        if (busy_a !== 1'b1 || va.data_valid !== 1'b0 || va.data_out !== tv[0])
            $display("FAIL in_hold: got busy=%b vld=%b data=%h, expected busy=1 vld=0 data=%h",
                     busy_a, va.data_valid, va.data_out, tv[0]);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({va.data_out, va.exp_parity, va.data_valid, va.vec_idx, busy_a, done_a} !== '0)
            $display("FAIL async_reset: got data=%h par=%b vld=%b idx=%0d busy=%b done=%b, expected all 0",
                     va.data_out, va.exp_parity, va.data_valid, va.vec_idx, busy_a, done_a);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        qa.delete();
        for (int k = 0; k < 4; k++) qa.push_back(mk(8'h00, k));
        gap_a = 1; last_a = -1;
        pulse_start(2'(SRC_TABLE), 1'b0);
        for (int i = 0; i < 200 && done_a !== 1'b1; i++) tick();
        chk_cnt++;
        if (qa.size() !== 0 || done_a !== 1'b1)
            $display("FAIL table_cleared: got %0d outstanding done=%b, expected 0 outstanding done=1",
                     qa.size(), done_a);
        else pass_cnt++;
        mon_a = 0; gap_a = 0;
        va.data_ready = 1'b0;
        do_stop();
    endtask

    initial begin
        test_reset();
        test_table_oneshot();
        test_back_to_back();
        test_ready_toggle();
        test_sources();
        test_stop_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
